// File: rtl/ooo_fetch_stage.sv
// ooo_fetch_stage
//   Front end of the out-of-order pipeline. Issues instruction reads on the
//   generic bus, chooses the next PC (trap insert > execute redirect >
//   predictor > pc+4), and fills the fetch/decode latch for the decode stage.
//   Bus transactions still in flight when a redirect arrives are drained and
//   their data dropped. A response that decode cannot take is parked in a
//   one-entry skid register, so no instruction is lost or duplicated.
//
// Ports
//   CLK, nRST                      clock, asynchronous active-low reset
//   halt                           sticky core halt
//   imem_ren/addr/rdata/busy/fault generic instruction bus
//   predict_taken/target           BTB lookup for the current pc
//   redirect_valid/pc              correction from execute
//   insert_pc/priv_pc              trap or return insertion
//   pc_en, stall_fd, if_id_flush   pipeline control
//   instr, pc, pc4, prediction,
//   token, mal_insn, fault_insn    fetch/decode latch outputs
module ooo_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  output logic        imem_ren,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_busy,
  input  logic        imem_fault,
  input  logic        predict_taken,
  input  logic [31:0] predict_target,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        insert_pc,
  input  logic [31:0] priv_pc,
  input  logic        pc_en,
  input  logic        stall_fd,
  input  logic        if_id_flush,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        prediction,
  output logic        token,
  output logic        mal_insn,
  output logic        fault_insn
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN, HALTED} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] pend_pc;

  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic [31:0] skid_pc4;
  logic        skid_pred;
  logic        skid_fault;

  // Set once the misaligned-fetch marker has been handed to decode, so the
  // marker is delivered exactly once while fetch waits for a redirect.
  logic        mal_done;

  logic        misaligned;
  logic        redir;
  logic [31:0] redir_target;
  logic [31:0] pc_plus4;
  logic [31:0] seq_target;
  logic        complete;
  logic        outstanding;
  logic        accept;
  logic        flush_now;
  logic        take_mal;
  logic [31:0] fetch_data;

  assign misaligned   = (fetch_pc[1:0] != 2'b00);
  assign redir        = insert_pc | redirect_valid;
  assign redir_target = insert_pc ? priv_pc : redirect_pc;
  assign pc_plus4     = fetch_pc + 32'd4;
  assign seq_target   = predict_taken ? predict_target : pc_plus4;

  // DRAIN keeps requesting the old address so the in-flight beat can finish.
  assign imem_ren  = nRST & (((state == FETCH) & ~halt & ~misaligned) |
                             (state == DRAIN));
  assign imem_addr = fetch_pc;

  assign complete    = imem_ren & ~imem_busy;
  assign outstanding = imem_ren & imem_busy;
  assign accept      = pc_en & ~stall_fd;
  assign flush_now   = if_id_flush & pc_en;
  assign fetch_data  = imem_fault ? NOP_INSTR : imem_rdata;

  assign take_mal = (state == FETCH) & misaligned & ~mal_done & ~halt &
                    ~redir & ~flush_now & accept;

  // Fetch control: PC, pending redirect target, skid entry and state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= FETCH;
      fetch_pc   <= RESET_PC;
      pend_pc    <= RESET_PC;
      skid_valid <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= 32'd0;
      skid_pc4   <= 32'd0;
      skid_pred  <= 1'b0;
      skid_fault <= 1'b0;
      mal_done   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (halt) begin
            state <= HALTED;
          end else if (redir) begin
            mal_done <= 1'b0;
            if (outstanding) begin
              state   <= DRAIN;
              pend_pc <= redir_target;
            end else begin
              fetch_pc <= redir_target;
            end
          end else if (complete) begin
            fetch_pc <= seq_target;
            // Decode cannot take it this cycle: park the response.
            if (!accept) begin
              state      <= HOLD;
              skid_valid <= 1'b1;
              skid_instr <= fetch_data;
              skid_pc    <= fetch_pc;
              skid_pc4   <= pc_plus4;
              skid_pred  <= predict_taken;
              skid_fault <= imem_fault;
            end
          end else if (take_mal) begin
            mal_done <= 1'b1;
          end
        end
        HOLD: begin
          if (halt) begin
            state      <= HALTED;
            skid_valid <= 1'b0;
          end else if (redir) begin
            state      <= FETCH;
            fetch_pc   <= redir_target;
            skid_valid <= 1'b0;
            mal_done   <= 1'b0;
          end else if (accept && !if_id_flush) begin
            state      <= FETCH;
            skid_valid <= 1'b0;
          end
        end
        DRAIN: begin
          // A redirect in the completing cycle is newer than pend_pc.
          if (complete) begin
            state    <= FETCH;
            fetch_pc <= redir ? redir_target : pend_pc;
          end else if (redir) begin
            pend_pc <= redir_target;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Fetch/decode latch. Redirects and halt squash whatever fetch produced
  // this cycle; a stalled or disabled pipeline keeps the current contents.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      instr      <= NOP_INSTR;
      pc         <= 32'd0;
      pc4        <= 32'd0;
      prediction <= 1'b0;
      token      <= 1'b0;
      mal_insn   <= 1'b0;
      fault_insn <= 1'b0;
    end else if (flush_now || redir || halt || (state == HALTED)) begin
      instr      <= NOP_INSTR;
      pc         <= 32'd0;
      pc4        <= 32'd0;
      prediction <= 1'b0;
      token      <= 1'b0;
      mal_insn   <= 1'b0;
      fault_insn <= 1'b0;
    end else if (!accept) begin
      instr      <= instr;
      pc         <= pc;
      pc4        <= pc4;
      prediction <= prediction;
      token      <= token;
      mal_insn   <= mal_insn;
      fault_insn <= fault_insn;
    end else if ((state == HOLD) && skid_valid) begin
      instr      <= skid_instr;
      pc         <= skid_pc;
      pc4        <= skid_pc4;
      prediction <= skid_pred;
      token      <= 1'b1;
      mal_insn   <= 1'b0;
      fault_insn <= skid_fault;
    end else if ((state == FETCH) && complete) begin
      instr      <= fetch_data;
      pc         <= fetch_pc;
      pc4        <= pc_plus4;
      prediction <= predict_taken;
      token      <= 1'b1;
      mal_insn   <= 1'b0;
      fault_insn <= imem_fault;
    end else if (take_mal) begin
      instr      <= NOP_INSTR;
      pc         <= fetch_pc;
      pc4        <= pc_plus4;
      prediction <= 1'b0;
      token      <= 1'b1;
      mal_insn   <= 1'b1;
      fault_insn <= 1'b0;
    end else begin
      instr      <= NOP_INSTR;
      pc         <= 32'd0;
      pc4        <= 32'd0;
      prediction <= 1'b0;
      token      <= 1'b0;
      mal_insn   <= 1'b0;
      fault_insn <= 1'b0;
    end
  end

endmodule
